// File: rtl/mesi_cpu_agent.sv
// Per-CPU MESI coherence agent in front of the mesi_isc interconnect: direct-mapped tag/state
// array, CPU miss handling over mbus, snoop/enable handling over cbus. Optional: MESI_AGENT_WB_EN.
module mesi_cpu_agent #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int LINES_LOG2     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req_i,
    input  logic                      cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
    output logic                      cpu_done_o,
    output logic                      cpu_hit_o,
    output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
    input  logic                      mbus_ack_i,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    output logic                      cbus_ack_o
);
    localparam int LINES  = 1 << LINES_LOG2;
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int TAG_W  = ADDR_WIDTH - LINES_LOG2 - 2;

    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP      = MBUS_CMD_WIDTH'(3'd0);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR       = MBUS_CMD_WIDTH'(3'd1);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD       = MBUS_CMD_WIDTH'(3'd2);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3'd3);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(3'd4);

    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(3'd1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(3'd2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3'd3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(3'd4);

    localparam logic [1:0] LS_I = 2'd0;
    localparam logic [1:0] LS_S = 2'd1;
    localparam logic [1:0] LS_M = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BROAD     = 3'd1,
        ST_WAIT_EN   = 3'd2,
        ST_ACCESS    = 3'd3,
        ST_SNOOP_ACK = 3'd4,
        ST_WB        = 3'd5
    } state_t;

    // WR_SNOOP invalidates; RD_SNOOP leaves at most a shared copy.
    function automatic logic [1:0] snoop_update(input logic [1:0] cur, input logic is_wr);
        logic [1:0] res;
        if (is_wr) begin
            res = LS_I;
        end else if (cur == LS_I) begin
            res = LS_I;
        end else begin
            res = LS_S;
        end
        return res;
    endfunction

    state_t                    state_r, state_nxt_s, ret_r, ret_nxt_s;
    logic [WORD_W-1:0]         req_word_r, req_word_nxt_s;
    logic                      req_we_r, req_we_nxt_s;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_r, mbus_cmd_nxt_s;
    logic [ADDR_WIDTH-1:0]     mbus_addr_r, mbus_addr_nxt_s;
    logic                      cbus_ack_r, cbus_ack_nxt_s;
    logic                      cpu_done_r, cpu_done_nxt_s;
    logic                      cpu_hit_r, cpu_hit_nxt_s;

    logic [1:0]                line_state_r [LINES];
    logic [TAG_W-1:0]          tag_r        [LINES];

    logic                      ls_we_s, tag_we_s;
    logic [LINES_LOG2-1:0]     ls_idx_s;
    logic [1:0]                ls_val_s;

    logic [LINES_LOG2-1:0]     cpu_idx_s, cb_idx_s, req_idx_s;
    logic [TAG_W-1:0]          cpu_tag_s, cb_tag_s, req_tag_s;
    logic [1:0]                cpu_state_s, cb_state_s;
    logic                      cpu_hit_s, cb_hit_s, cb_is_wr_s;
    logic                      snoop_pending_s, snp_accept_s, en_match_s;
    logic                      unused_ok_s;

    assign cpu_idx_s   = cpu_addr_i[LINES_LOG2+1:2];
    assign cpu_tag_s   = cpu_addr_i[ADDR_WIDTH-1:LINES_LOG2+2];
    assign cpu_state_s = line_state_r[cpu_idx_s];
    assign cpu_hit_s   = (cpu_state_s != LS_I) && (tag_r[cpu_idx_s] == cpu_tag_s);

    assign cb_idx_s    = cbus_addr_i[LINES_LOG2+1:2];
    assign cb_tag_s    = cbus_addr_i[ADDR_WIDTH-1:LINES_LOG2+2];
    assign cb_state_s  = line_state_r[cb_idx_s];
    assign cb_hit_s    = (cb_state_s != LS_I) && (tag_r[cb_idx_s] == cb_tag_s);
    assign cb_is_wr_s  = (cbus_cmd_i == CBUS_WR_SNOOP);

    assign req_idx_s   = req_word_r[LINES_LOG2-1:0];
    assign req_tag_s   = req_word_r[WORD_W-1:LINES_LOG2];

    assign snoop_pending_s = (cbus_cmd_i == CBUS_WR_SNOOP) || (cbus_cmd_i == CBUS_RD_SNOOP);
    assign snp_accept_s    = snoop_pending_s && ((state_r == ST_IDLE) || (state_r == ST_WAIT_EN));
    assign en_match_s      = (cbus_cmd_i == (req_we_r ? CBUS_EN_WR : CBUS_EN_RD)) &&
                             (cbus_addr_i[ADDR_WIDTH-1:2] == req_word_r);

    // Byte-offset bits carry no information for word-aligned traffic.
    assign unused_ok_s = ^{cpu_addr_i[1:0], cbus_addr_i[1:0]};

`ifdef MESI_AGENT_WB_EN
    logic [WORD_W-1:0]     snp_word_r, snp_word_nxt_s;
    logic                  snp_wr_r, snp_wr_nxt_s;
    logic [LINES_LOG2-1:0] snp_idx_s;
    logic                  snp_hit_s;

    assign snp_idx_s = snp_word_r[LINES_LOG2-1:0];
    assign snp_hit_s = (line_state_r[snp_idx_s] != LS_I) &&
                       (tag_r[snp_idx_s] == snp_word_r[WORD_W-1:LINES_LOG2]);
`endif

    // Next-state, output and array-update decode
    always_comb begin
        state_nxt_s     = state_r;
        ret_nxt_s       = ret_r;
        req_word_nxt_s  = req_word_r;
        req_we_nxt_s    = req_we_r;
        mbus_cmd_nxt_s  = mbus_cmd_r;
        mbus_addr_nxt_s = mbus_addr_r;
        cbus_ack_nxt_s  = 1'b0;
        cpu_done_nxt_s  = 1'b0;
        cpu_hit_nxt_s   = 1'b0;
        ls_we_s         = 1'b0;
        ls_idx_s        = cpu_idx_s;
        ls_val_s        = LS_I;
        tag_we_s        = 1'b0;
`ifdef MESI_AGENT_WB_EN
        snp_word_nxt_s  = snp_word_r;
        snp_wr_nxt_s    = snp_wr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                // cpu_done_r guards against re-serving a request still held during its done cycle
                if (!snp_accept_s && cpu_req_i && !cpu_done_r) begin
                    req_word_nxt_s = cpu_addr_i[ADDR_WIDTH-1:2];
                    req_we_nxt_s   = cpu_we_i;
                    if (cpu_hit_s && (!cpu_we_i || cpu_state_s[1])) begin
                        cpu_done_nxt_s = 1'b1;
                        cpu_hit_nxt_s  = 1'b1;
                        ls_we_s        = cpu_we_i;
                        ls_idx_s       = cpu_idx_s;
                        ls_val_s       = LS_M;
                    end else begin
                        state_nxt_s     = ST_BROAD;
                        mbus_cmd_nxt_s  = cpu_we_i ? MBUS_WR_BROAD : MBUS_RD_BROAD;
                        mbus_addr_nxt_s = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_BROAD: begin
                if (mbus_ack_i) begin
                    mbus_cmd_nxt_s = MBUS_NOP;
                    state_nxt_s    = ST_WAIT_EN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_WAIT_EN: begin
                if (!snp_accept_s && en_match_s) begin
                    cbus_ack_nxt_s  = 1'b1;
                    state_nxt_s     = ST_ACCESS;
                    mbus_cmd_nxt_s  = req_we_r ? MBUS_WR : MBUS_RD;
                    mbus_addr_nxt_s = {req_word_r, 2'b00};
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_ACCESS: begin
                if (mbus_ack_i) begin
                    mbus_cmd_nxt_s = MBUS_NOP;
                    ls_we_s        = 1'b1;
                    ls_idx_s       = req_idx_s;
                    ls_val_s       = req_we_r ? LS_M : LS_S;
                    tag_we_s       = 1'b1;
                    cpu_done_nxt_s = 1'b1;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SNOOP_ACK: begin
                state_nxt_s = ret_r;
            end
`ifdef MESI_AGENT_WB_EN
            ST_WB: begin
                if (mbus_ack_i) begin
                    mbus_cmd_nxt_s = MBUS_NOP;
                    cbus_ack_nxt_s = 1'b1;
                    state_nxt_s    = ST_SNOOP_ACK;
                    ls_we_s        = snp_hit_s;
                    ls_idx_s       = snp_idx_s;
                    ls_val_s       = snoop_update(line_state_r[snp_idx_s], snp_wr_r);
                end else begin
                    state_nxt_s = state_r;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (snp_accept_s) begin
            ret_nxt_s = state_r;
`ifdef MESI_AGENT_WB_EN
            snp_word_nxt_s = cbus_addr_i[ADDR_WIDTH-1:2];
            snp_wr_nxt_s   = cb_is_wr_s;
            if (cb_hit_s && (cb_state_s == LS_M)) begin
                state_nxt_s     = ST_WB;
                mbus_cmd_nxt_s  = MBUS_WR;
                mbus_addr_nxt_s = {cbus_addr_i[ADDR_WIDTH-1:2], 2'b00};
            end else begin
                cbus_ack_nxt_s = 1'b1;
                state_nxt_s    = ST_SNOOP_ACK;
                ls_we_s        = cb_hit_s;
                ls_idx_s       = cb_idx_s;
                ls_val_s       = snoop_update(cb_state_s, cb_is_wr_s);
            end
`else
            cbus_ack_nxt_s = 1'b1;
            state_nxt_s    = ST_SNOOP_ACK;
            ls_we_s        = cb_hit_s;
            ls_idx_s       = cb_idx_s;
            ls_val_s       = snoop_update(cb_state_s, cb_is_wr_s);
`endif
        end else begin
            ret_nxt_s = ret_r;
        end
    end

    // FSM state, request context and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ret_r       <= ST_IDLE;
            req_word_r  <= {WORD_W{1'b0}};
            req_we_r    <= 1'b0;
            mbus_cmd_r  <= MBUS_NOP;
            mbus_addr_r <= {ADDR_WIDTH{1'b0}};
            cbus_ack_r  <= 1'b0;
            cpu_done_r  <= 1'b0;
            cpu_hit_r   <= 1'b0;
`ifdef MESI_AGENT_WB_EN
            snp_word_r  <= {WORD_W{1'b0}};
            snp_wr_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            ret_r       <= ret_nxt_s;
            req_word_r  <= req_word_nxt_s;
            req_we_r    <= req_we_nxt_s;
            mbus_cmd_r  <= mbus_cmd_nxt_s;
            mbus_addr_r <= mbus_addr_nxt_s;
            cbus_ack_r  <= cbus_ack_nxt_s;
            cpu_done_r  <= cpu_done_nxt_s;
            cpu_hit_r   <= cpu_hit_nxt_s;
`ifdef MESI_AGENT_WB_EN
            snp_word_r  <= snp_word_nxt_s;
            snp_wr_r    <= snp_wr_nxt_s;
`endif
        end
    end

    // Line state array; reset invalidates every line
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                line_state_r[i] <= LS_I;
            end
        end else if (ls_we_s) begin
            line_state_r[ls_idx_s] <= ls_val_s;
        end
    end

    // Tag array, written only on fill; contents are meaningless while the line is I
    always_ff @(posedge clk) begin
        if (!rst && tag_we_s) begin
            tag_r[req_idx_s] <= req_tag_s;
        end
    end

    assign cpu_done_o  = cpu_done_r;
    assign cpu_hit_o   = cpu_hit_r;
    assign mbus_cmd_o  = mbus_cmd_r;
    assign mbus_addr_o = mbus_addr_r;
    assign cbus_ack_o  = cbus_ack_r;

endmodule

// File: tb/tb_mesi_cpu_agent.sv
// Directed bench for mesi_cpu_agent: load/store miss and hit flows, snoops, priority and reset abort.
module tb_mesi_cpu_agent;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic        cpu_done_o;
    logic        cpu_hit_o;
    logic [2:0]  mbus_cmd_o;
    logic [31:0] mbus_addr_o;
    logic        mbus_ack_i;
    logic [2:0]  cbus_cmd_i;
    logic [31:0] cbus_addr_i;
    logic        cbus_ack_o;

    int total = 0;
    int bad   = 0;

    mesi_cpu_agent dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_done_o(cpu_done_o), .cpu_hit_o(cpu_hit_o),
        .mbus_cmd_o(mbus_cmd_o), .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
        .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_ack_o(cbus_ack_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0;
        mbus_ack_i = 1'b0; cbus_cmd_i = 3'd0; cbus_addr_i = 32'h0;
        tick(); tick();
        check("rst_mbus_cmd", {29'd0, mbus_cmd_o}, 32'd0);
        check("rst_mbus_addr", mbus_addr_o, 32'd0);
        check("rst_cbus_ack", {31'd0, cbus_ack_o}, 32'd0);
        check("rst_done", {31'd0, cpu_done_o}, 32'd0);
        rst = 1'b0;
        tick();

        // load miss 0x10
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
        tick();
        check("ld_rd_broad", {29'd0, mbus_cmd_o}, 32'd4);
        check("ld_rd_broad_addr", mbus_addr_o, 32'h10);
        tick();
        check("ld_rd_broad_held", {29'd0, mbus_cmd_o}, 32'd4);
        mbus_ack_i = 1'b1;
        tick();
        mbus_ack_i = 1'b0;
        check("ld_broad_nop", {29'd0, mbus_cmd_o}, 32'd0);
        cbus_cmd_i = 3'd4; cbus_addr_i = 32'h10;
        tick();
        cbus_cmd_i = 3'd0;
        check("ld_en_ack", {31'd0, cbus_ack_o}, 32'd1);
        check("ld_rd", {29'd0, mbus_cmd_o}, 32'd2);
        tick();
        check("ld_en_ack_drop", {31'd0, cbus_ack_o}, 32'd0);
        mbus_ack_i = 1'b1;
        tick();
        mbus_ack_i = 1'b0; cpu_req_i = 1'b0;
        check("ld_miss_done", {31'd0, cpu_done_o}, 32'd1);
        check("ld_miss_hit", {31'd0, cpu_hit_o}, 32'd0);
        check("ld_miss_nop", {29'd0, mbus_cmd_o}, 32'd0);
        check("ld_line_S", {30'd0, dut.line_state_r[4]}, 32'd1);
        tick();
        check("ld_done_pulse", {31'd0, cpu_done_o}, 32'd0);

        // load hit
        cpu_req_i = 1'b1;
        tick();
        cpu_req_i = 1'b0;
        check("ldhit_done", {31'd0, cpu_done_o}, 32'd1);
        check("ldhit_hit", {31'd0, cpu_hit_o}, 32'd1);
        check("ldhit_nop", {29'd0, mbus_cmd_o}, 32'd0);
        tick();

        // snoop miss: same index, different tag
        cbus_cmd_i = 3'd2; cbus_addr_i = 32'h30;
        tick();
        cbus_cmd_i = 3'd0;
        check("snmiss_ack", {31'd0, cbus_ack_o}, 32'd1);
        check("snmiss_line", {30'd0, dut.line_state_r[4]}, 32'd1);
        tick();
        check("snmiss_ack_drop", {31'd0, cbus_ack_o}, 32'd0);

        // store to S line goes to the bus
        cpu_req_i = 1'b1; cpu_we_i = 1'b1;
        tick();
        check("st_wr_broad", {29'd0, mbus_cmd_o}, 32'd3);
        mbus_ack_i = 1'b1;
        tick();
        mbus_ack_i = 1'b0;
        cbus_cmd_i = 3'd3; cbus_addr_i = 32'h10;
        tick();
        cbus_cmd_i = 3'd0;
        check("st_en_ack", {31'd0, cbus_ack_o}, 32'd1);
        check("st_wr", {29'd0, mbus_cmd_o}, 32'd1);
        mbus_ack_i = 1'b1;
        tick();
        mbus_ack_i = 1'b0; cpu_req_i = 1'b0;
        check("st_done", {31'd0, cpu_done_o}, 32'd1);
        check("st_hit", {31'd0, cpu_hit_o}, 32'd0);
        check("st_line_M", {30'd0, dut.line_state_r[4]}, 32'd3);
        tick();
        cpu_req_i = 1'b1;
        tick();
        cpu_req_i = 1'b0;
        check("st2_hit", {31'd0, cpu_hit_o}, 32'd1);
        check("st2_done", {31'd0, cpu_done_o}, 32'd1);
        check("st2_nop", {29'd0, mbus_cmd_o}, 32'd0);
        tick();

        // RD_SNOOP on M line
        cbus_cmd_i = 3'd2; cbus_addr_i = 32'h10;
        tick();
`ifdef MESI_AGENT_WB_EN
        check("wb_cmd", {29'd0, mbus_cmd_o}, 32'd1);
        check("wb_addr", mbus_addr_o, 32'h10);
        check("wb_no_ack", {31'd0, cbus_ack_o}, 32'd0);
        mbus_ack_i = 1'b1;
        tick();
        mbus_ack_i = 1'b0;
`endif
        cbus_cmd_i = 3'd0;
        check("rdsnoop_ack", {31'd0, cbus_ack_o}, 32'd1);
        check("rdsnoop_line_S", {30'd0, dut.line_state_r[4]}, 32'd1);
        tick();
        check("rdsnoop_ack_drop", {31'd0, cbus_ack_o}, 32'd0);

        // snoop and CPU load together: snoop first
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10;
        cbus_cmd_i = 3'd1; cbus_addr_i = 32'h10;
        tick();
        cbus_cmd_i = 3'd0;
        check("prio_ack", {31'd0, cbus_ack_o}, 32'd1);
        check("prio_no_done", {31'd0, cpu_done_o}, 32'd0);
        check("prio_line_I", {30'd0, dut.line_state_r[4]}, 32'd0);
        tick();
        check("prio_wait_nop", {29'd0, mbus_cmd_o}, 32'd0);
        tick();
        check("prio_rd_broad", {29'd0, mbus_cmd_o}, 32'd4);
        check("prio_done_low", {31'd0, cpu_done_o}, 32'd0);
        mbus_ack_i = 1'b1;
        tick();
        mbus_ack_i = 1'b0;

        // mismatched enables are ignored
        cbus_cmd_i = 3'd4; cbus_addr_i = 32'h14;
        tick();
        check("en_bad_addr", {31'd0, cbus_ack_o}, 32'd0);
        cbus_cmd_i = 3'd3; cbus_addr_i = 32'h10;
        tick();
        check("en_bad_cmd", {31'd0, cbus_ack_o}, 32'd0);
        cbus_cmd_i = 3'd4;
        tick();
        cbus_cmd_i = 3'd0;
        check("en_good", {31'd0, cbus_ack_o}, 32'd1);
        check("access_rd", {29'd0, mbus_cmd_o}, 32'd2);

        // reset during ACCESS
        rst = 1'b1;
        tick();
        check("abort_done", {31'd0, cpu_done_o}, 32'd0);
        check("abort_mbus", {29'd0, mbus_cmd_o}, 32'd0);
        check("abort_addr", mbus_addr_o, 32'd0);
        check("abort_ack", {31'd0, cbus_ack_o}, 32'd0);
        check("abort_line_I", {30'd0, dut.line_state_r[4]}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_miss", {29'd0, mbus_cmd_o}, 32'd4);
        check("post_rst_no_hit", {31'd0, cpu_done_o}, 32'd0);
        cpu_req_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mesi_cpu_agent.md
Name: mesi_cpu_agent

Overview:
Per-CPU coherence agent that sits directly upstream of the mesi_isc interconnect; one instance drives each mbus/cbus port pair. It keeps a small direct-mapped MESI tag/state array and turns CPU load/store requests into main-bus commands and handshakes. It also answers coherence-bus snoops and enables, updating line states so the interconnect sees a well-behaved agent.

Parameters:
ADDR_WIDTH, 32, address width of cpu, mbus and cbus addresses
MBUS_CMD_WIDTH, 3, main-bus command width
CBUS_CMD_WIDTH, 3, coherence-bus command width
LINES_LOG2, 3, log2 of tracked lines (8 lines)

Ports:
clk  input  1  system clock
rst  input  1  system reset; synchronous, active-high
cpu_req_i  input  1  CPU request valid; held until cpu_done_o
cpu_we_i  input  1  1=store, 0=load; stable while cpu_req_i
cpu_addr_i  input  ADDR_WIDTH  request address, word-aligned
cpu_done_o  output  1  one-cycle pulse: request complete
cpu_hit_o  output  1  qualifies cpu_done_o: 1=served locally, no bus traffic
mbus_cmd_o  output  MBUS_CMD_WIDTH  main-bus command: NOP=0 WR=1 RD=2 WR_BROAD=3 RD_BROAD=4
mbus_addr_o  output  ADDR_WIDTH  main-bus address, bits[1:0] forced 0
mbus_ack_i  input  1  main-bus acknowledge from interconnect
cbus_cmd_i  input  CBUS_CMD_WIDTH  coherence command: NOP=0 WR_SNOOP=1 RD_SNOOP=2 EN_WR=3 EN_RD=4
cbus_addr_i  input  ADDR_WIDTH  coherence-bus address
cbus_ack_o  output  1  coherence-bus acknowledge, one-cycle pulse

Behaviour:
- Address split: index = addr[LINES_LOG2+1:2]; tag = addr[ADDR_WIDTH-1:LINES_LOG2+2]. Hit = state!=I and tag equal.
- Line state encoding is 2 bits: I=0, S=1, E=2, M=3. Reset clears all states to I. Tags are don't-care at reset.
- Reset outputs: mbus_cmd_o=NOP, mbus_addr_o=0, cbus_ack_o=0, cpu_done_o=0, cpu_hit_o=0. FSM goes to IDLE. Reset mid-transaction drops it with no completion pulse.
- FSM states: IDLE, BROAD, WAIT_EN, ACCESS, SNOOP_ACK (plus WB with the optional feature).
- IDLE transitions, one request evaluated per cycle:
  - Load hit, or store hit in E/M: cpu_done_o=1 and cpu_hit_o=1 in the cycle after cpu_req_i is sampled. A store sets the line to M.
  - Load miss: go to BROAD with RD_BROAD.
  - Store miss, or store hit in S: go to BROAD with WR_BROAD.
- BROAD: mbus_cmd_o/mbus_addr_o held until the cycle mbus_ack_i=1, then drop to NOP next cycle and go to WAIT_EN.
- WAIT_EN:
  - Waits for cbus_cmd_i=EN_RD (load) or EN_WR (store) with cbus_addr_i matching the request.
  - Pulses cbus_ack_o the next cycle, then goes to ACCESS.
  - A mismatched EN command is ignored; no ack.
- ACCESS: drive RD or WR until mbus_ack_i, then:
  - Install tag; state becomes S for a load, M for a store.
  - Pulse cpu_done_o with cpu_hit_o=0, then return to IDLE.
- Snoops (WR_SNOOP / RD_SNOOP) are accepted in IDLE and WAIT_EN only. In BROAD and ACCESS they stay pending; cbus_cmd_i is held by the interconnect until acked.
  - On acceptance go to SNOOP_ACK: update the state, then pulse cbus_ack_o exactly one cycle after acceptance.
  - WR_SNOOP on a hit: line becomes I.
  - RD_SNOOP on a hit in E/M: line becomes S. A hit in S is unchanged.
  - Snoop miss: ack only.
  - SNOOP_ACK returns to the state it came from.
- Simultaneous events:
  - In IDLE, a pending snoop wins over cpu_req_i; the CPU request waits.
  - A snoop that invalidates the line of an in-progress WAIT_EN store does not cancel it; ACCESS still installs M.
- cbus_ack_o is never high for two consecutive cycles. It is never asserted with cbus_cmd_i=NOP.

Optional Feature:
MESI_AGENT_WB_EN.
- Defined: a snoop hitting an M line first enters WB.
  - WB drives mbus_cmd_o=WR, mbus_addr_o=line address until mbus_ack_i.
  - Then it proceeds to SNOOP_ACK, applying the normal state update.
  - The ack latency for that snoop is write-back completion + 1 cycle.
- Undefined: no WB state. M lines are downgraded or invalidated with no bus write, and ack latency is always 1 cycle.

Test Plan:
- Reset, then load 0x0000_0010 -> RD_BROAD held until ack; EN_RD 0x10 -> cbus_ack_o pulse next cycle; RD until ack -> cpu_done_o=1, cpu_hit_o=0; line 4 state S.
- Repeat load 0x10 -> cpu_done_o=1, cpu_hit_o=1 one cycle after req; mbus_cmd_o stays NOP.
- Store 0x10 while in S -> WR_BROAD, EN_WR, WR sequence; final state M. A second store to 0x10 hits locally.
- With 0x10 in M, RD_SNOOP 0x10:
  - WB_EN undefined: ack after 1 cycle, state S.
  - WB_EN defined: WR 0x10 on mbus first; ack 1 cycle after mbus_ack_i.
- In IDLE, cpu_req_i and WR_SNOOP 0x10 arrive in the same cycle -> snoop acked first, line I; the CPU load then misses and issues RD_BROAD.
- Assert rst during ACCESS -> next cycle all outputs 0/NOP, no cpu_done_o; a subsequent load of 0x10 misses.
